echo_interconnect: RTL and testbench
====================================

Name: echo_interconnect

Overview:
- N-to-1 packet merge fabric with valid/ready handshaking on every side.
- Each input channel has a one-entry register slice ("echo" stage).
- A fixed-priority arbiter selects among the occupied input slices, highest index wins, and moves the winner into a one-entry output register slice.
- Used to funnel packets from several producer units into one consumer.

Parameters:
- DATA_WIDTH, 192, packet width in bits (equals the codebase PACKET_WIDTH).
- CONNECT_NUM, 3, number of input channels; must be >= 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- RECEIVE_VALID  input  CONNECT_NUM  bit i: channel i offers a packet.
- RECEIVE_READY  output  CONNECT_NUM  bit i: channel i slice can accept.
- RECEIVE_DATA  input  DATA_WIDTH*CONNECT_NUM  packed packets; channel i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- SEND_VALID  output  1  output slice holds a packet.
- SEND_READY  input  1  consumer accepts the packet this cycle.
- SEND_DATA  output  DATA_WIDTH  packet held by the output slice.

Behaviour:
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1.
  - Once raised, a valid stays high with stable data until the transfer.
  - Ready may be high with valid low.
- Input slice i, state full_i plus data register:
  - RECEIVE_READY[i] = ~full_i, purely registered with no combinational input paths.
  - On an input transfer, latch the channel i slice of RECEIVE_DATA and set full_i.
  - full_i clears on the edge where slice i is granted.
- Output slice, state out_full plus data register:
  - SEND_VALID = out_full; SEND_DATA = output data register.
  - load_en = ~out_full | SEND_READY.
- Arbiter (combinational on full_i and load_en only):
  - grant = highest index i with full_i = 1, qualified by load_en.
  - On a granted edge: output register <= slice data, out_full <= 1, full_grant <= 0.
  - Without a grant: if SEND_READY & out_full, then out_full <= 0.
- At most one packet moves per cycle.
- Latency:
  - Input accepted at edge k: full_i = 1 after edge k.
  - With the output free, SEND_VALID = 1 after edge k+1 (2 cycles).
- Per-channel throughput: one packet every 2 cycles, because ready is low while full.
- Output stage sustains one packet per cycle: drain and refill occur on the same edge when SEND_READY = 1.
- Fixed priority. Lower channels may starve while a higher channel keeps refilling; this is permitted.
- Simultaneous events:
  - An input refill on the edge its slice is granted cannot occur, since ready was 0.
  - Packets from different channels are output in priority order, not arrival order.
  - Per-channel order is preserved.
- Reset, including mid-operation:
  - All full_i and out_full clear, so SEND_VALID = 0 and RECEIVE_READY = all 1s after the reset edge.
  - In-flight packets are discarded.
  - Data registers need not be reset; SEND_DATA is don't-care while SEND_VALID = 0.
- SEND_DATA never changes while SEND_VALID = 1 and SEND_READY = 0.

Test Plan:
- Reset: RST = 1 for one cycle, all valids 0 -> SEND_VALID = 0, RECEIVE_READY = 3'b111 after the edge.
- Single channel: channel 1 sends 0xA5..A5 with SEND_READY = 1 -> SEND_VALID rises 2 edges after acceptance, SEND_DATA = 0xA5..A5, then SEND_VALID drops.
- Priority order: channels 0, 1, 2 present random packets P0, P1, P2 simultaneously, consumer always ready -> output order P2, P1, P0 with data exact.
- Backpressure: P2, P1, P0 loaded, SEND_READY = 0 for 5 cycles -> SEND_DATA holds P2 stable, RECEIVE_READY[2] = 1 and [1:0] = 0. Release -> P2, P1, P0 on consecutive cycles.
- Staggered start: channel 0 sends first, then channel 2 three cycles later -> P0 is output first (already moved), then P2.
- Stress and mid-reset: 200 iterations of random simultaneous sends in both issue orders (0,1,2 and 2,1,0) -> always received 2, 1, 0. Then assert RST with all slices full -> SEND_VALID = 0 next cycle and no stale packet emitted.

Source files
------------

// File: rtl/echo_interconnect.sv
// N-to-1 merge: one-entry slice per input, highest-index-wins arbiter into a one-entry output slice.
// Latency 2 cycles input to SEND_VALID; input ready is registered, output drains and refills on the same edge.
module echo_interconnect #(
   parameter int DATA_WIDTH  = 192,
   parameter int CONNECT_NUM = 3
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic [CONNECT_NUM-1:0]            RECEIVE_VALID,
   output logic [CONNECT_NUM-1:0]            RECEIVE_READY,
   input  logic [DATA_WIDTH*CONNECT_NUM-1:0] RECEIVE_DATA,
   output logic                              SEND_VALID,
   input  logic                              SEND_READY,
   output logic [DATA_WIDTH-1:0]             SEND_DATA
);

   logic [CONNECT_NUM-1:0] r_full;
   logic [DATA_WIDTH-1:0]  r_slice_dat [CONNECT_NUM];
   logic                   r_out_full;
   logic [DATA_WIDTH-1:0]  r_out_dat;

   logic                   w_load_en;
   logic [CONNECT_NUM-1:0] w_accept;
   logic [CONNECT_NUM-1:0] w_grant;
   logic                   w_grant_any;
   logic [DATA_WIDTH-1:0]  w_grant_dat;

   assign w_load_en = ~r_out_full | SEND_READY;
   assign w_accept  = RECEIVE_VALID & ~r_full;

   // Later iterations overwrite earlier ones, so the highest occupied index wins.
   always_comb begin
      w_grant     = '0;
      w_grant_any = 1'b0;
      w_grant_dat = r_slice_dat[0];
      for (int i = 0; i < CONNECT_NUM; i++) begin
         if (r_full[i]) begin
            w_grant     = '0;
            w_grant[i]  = w_load_en;
            w_grant_any = w_load_en;
            w_grant_dat = r_slice_dat[i];
         end
      end
   end

   // Accept and grant are disjoint per slice: accept needs empty, grant needs full.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_full <= '0;
      end else begin
         r_full <= (r_full & ~w_grant) | w_accept;
      end
   end

   always_ff @(posedge CLK) begin
      for (int i = 0; i < CONNECT_NUM; i++) begin
         if (w_accept[i]) begin
            r_slice_dat[i] <= RECEIVE_DATA[DATA_WIDTH*i +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_out_full <= 1'b0;
      end else if (w_grant_any) begin
         r_out_full <= 1'b1;
      end else if (SEND_READY) begin
         r_out_full <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_grant_any) begin
         r_out_dat <= w_grant_dat;
      end
   end

   assign RECEIVE_READY = ~r_full;
   assign SEND_VALID    = r_out_full;
   assign SEND_DATA     = r_out_dat;

endmodule

// File: tb/tb_echo_interconnect.sv
// Scoreboard bench for echo_interconnect: expected packets queued at issue, compared at output.
module tb_echo_interconnect;

   localparam int DW = 192;
   localparam int CN = 3;

   logic               CLK = 1'b0;
   logic               RST;
   logic [CN-1:0]      RECEIVE_VALID;
   logic [CN-1:0]      RECEIVE_READY;
   logic [DW*CN-1:0]   RECEIVE_DATA;
   logic               SEND_VALID;
   logic               SEND_READY;
   logic [DW-1:0]      SEND_DATA;

   int                 n_tests = 0;
   int                 n_fail  = 0;
   logic [DW-1:0]      sb_q[$];
   logic [DW-1:0]      mon_exp;
   logic [DW-1:0]      held_dat;
   logic               hold_prev = 1'b0;
   logic               rand_bp   = 1'b0;

   echo_interconnect #(.DATA_WIDTH(DW), .CONNECT_NUM(CN)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .RECEIVE_VALID (RECEIVE_VALID),
      .RECEIVE_READY (RECEIVE_READY),
      .RECEIVE_DATA  (RECEIVE_DATA),
      .SEND_VALID    (SEND_VALID),
      .SEND_READY    (SEND_READY),
      .SEND_DATA     (SEND_DATA)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_pkt();
      logic [DW-1:0] p;
      for (int w = 0; w < DW/32; w++) p[32*w +: 32] = $urandom;
      return p;
   endfunction

   task automatic send(input int ch, input logic [DW-1:0] d);
      int   n = 0;
      logic rdy;
      RECEIVE_DATA[DW*ch +: DW] = d;
      RECEIVE_VALID[ch] = 1'b1;
      while (1) begin
         rdy = RECEIVE_READY[ch];
         @(posedge CLK);
         if (rdy || n >= 100) break;
         #1;
         n++;
      end
      #1;
      RECEIVE_VALID[ch] = 1'b0;
      check_val("send_accept", rdy, 1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb_q.size() > 0 && n < 500) begin
         @(posedge CLK);
         n++;
      end
      check_val("drain", sb_q.size(), 0);
      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      if (hold_prev) begin
         check_val("hold_vld", SEND_VALID, 1);
         check_val("hold_dat", SEND_DATA, held_dat);
      end
      hold_prev = SEND_VALID && !SEND_READY && !RST;
      held_dat  = SEND_DATA;
      if (SEND_VALID && SEND_READY && !RST) begin
         check_val("sb_nonempty", sb_q.size() > 0, 1);
         if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            check_val("out_dat", SEND_DATA, mon_exp);
         end
      end
   end

   always @(posedge CLK) begin
      if (rand_bp) begin
         #1;
         if (rand_bp) SEND_READY = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] p0, p1, p2, p3;
      RST           = 1'b1;
      RECEIVE_VALID = '0;
      RECEIVE_DATA  = '0;
      SEND_READY    = 1'b0;

      // reset
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check_val("rst_vld", SEND_VALID, 0);
      check_val("rst_rdy", RECEIVE_READY, 3'b111);

      // single channel latency
      @(posedge CLK); #1;
      SEND_READY = 1'b1;
      p1 = {24{8'hA5}};
      sb_q.push_back(p1);
      send(1, p1);
      @(negedge CLK);
      check_val("lat_k", SEND_VALID, 0);
      @(negedge CLK);
      check_val("lat_k1_vld", SEND_VALID, 1);
      check_val("lat_k1_dat", SEND_DATA, p1);
      @(negedge CLK);
      check_val("lat_k2_vld", SEND_VALID, 0);
      wait_drain();

      // priority order
      p0 = rand_pkt(); p1 = rand_pkt(); p2 = rand_pkt();
      sb_q.push_back(p2); sb_q.push_back(p1); sb_q.push_back(p0);
      fork
         send(0, p0);
         send(1, p1);
         send(2, p2);
      join
      wait_drain();

      // backpressure
      SEND_READY = 1'b0;
      p0 = rand_pkt(); p1 = rand_pkt(); p2 = rand_pkt();
      sb_q.push_back(p2); sb_q.push_back(p1); sb_q.push_back(p0);
      fork
         send(0, p0);
         send(1, p1);
         send(2, p2);
      join
      @(posedge CLK); #1;
      repeat (5) begin
         @(negedge CLK);
         check_val("bp_vld", SEND_VALID, 1);
         check_val("bp_dat", SEND_DATA, p2);
         check_val("bp_rdy", RECEIVE_READY, 3'b100);
      end
      @(posedge CLK); #1;
      SEND_READY = 1'b1;
      @(negedge CLK);
      check_val("rel_p2", SEND_DATA, p2);
      @(negedge CLK);
      check_val("rel_p1_vld", SEND_VALID, 1);
      check_val("rel_p1", SEND_DATA, p1);
      @(negedge CLK);
      check_val("rel_p0_vld", SEND_VALID, 1);
      check_val("rel_p0", SEND_DATA, p0);
      wait_drain();

      // staggered start
      p0 = rand_pkt(); p2 = rand_pkt();
      sb_q.push_back(p0);
      send(0, p0);
      repeat (3) @(posedge CLK);
      #1;
      sb_q.push_back(p2);
      send(2, p2);
      wait_drain();

      // stress with random backpressure, both issue orders
      rand_bp = 1'b1;
      for (int it = 0; it < 200; it++) begin
         p0 = rand_pkt(); p1 = rand_pkt(); p2 = rand_pkt();
         sb_q.push_back(p2); sb_q.push_back(p1); sb_q.push_back(p0);
         if (it % 2 == 0) begin
            fork
               send(0, p0);
               send(1, p1);
               send(2, p2);
            join
         end else begin
            fork
               send(2, p2);
               send(1, p1);
               send(0, p0);
            join
         end
         wait_drain();
      end
      rand_bp = 1'b0;
      @(posedge CLK); #2;
      SEND_READY = 1'b0;

      // mid-operation reset with every slice full
      p0 = rand_pkt(); p1 = rand_pkt(); p2 = rand_pkt(); p3 = rand_pkt();
      fork
         send(0, p0);
         send(1, p1);
         send(2, p2);
      join
      @(posedge CLK); #1;
      send(2, p3);
      @(negedge CLK);
      check_val("full_rdy", RECEIVE_READY, 3'b000);
      check_val("full_vld", SEND_VALID, 1);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check_val("mrst_vld", SEND_VALID, 0);
      check_val("mrst_rdy", RECEIVE_READY, 3'b111);
      SEND_READY = 1'b1;
      repeat (10) begin
         @(negedge CLK);
         check_val("no_stale", SEND_VALID, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
